// File: rtl/uart_hex_pkg.sv
// uart_hex_pkg: shared constants, state and character-class encodings for the UART hex word parser.
package uart_hex_pkg;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BADCHAR = 2'd1;
    localparam logic [1:0] ERR_TOOLONG = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DISCARD} state_e;
    typedef enum logic [2:0] {CLS_DIGIT, CLS_SEP, CLS_EOL, CLS_BS, CLS_BAD} cls_e;
endpackage

// File: rtl/hex_char_classify.sv
// hex_char_classify: maps one ASCII byte to a character class and hex nibble.
// 0x08/0x7F report CLS_BS only when RX_HEX_BKSP_EN is defined; otherwise they are CLS_BAD.
module hex_char_classify
    import uart_hex_pkg::*;
(
    input  logic [7:0] din_data,
    output logic [2:0] cls,
    output logic [3:0] nibble
);
    logic [7:0] lc;

    always_comb begin
        lc = din_data | 8'h20;
        cls = CLS_BAD;
        nibble = 4'd0;
        if (din_data >= 8'h30 && din_data <= 8'h39) begin
            cls = CLS_DIGIT;
            nibble = din_data[3:0];
        end else if (lc >= 8'h61 && lc <= 8'h66) begin
            // 'a'..'f' and 'A'..'F' both end in 1..6 in the low nibble
            cls = CLS_DIGIT;
            nibble = din_data[3:0] + 4'd9;
        end else if (din_data == CH_SP || din_data == CH_COMMA)
            cls = CLS_SEP;
        else if (din_data == CH_CR || din_data == CH_LF)
            cls = CLS_EOL;
`ifdef RX_HEX_BKSP_EN
        else if (din_data == CH_BS || din_data == CH_DEL)
            cls = CLS_BS;
`endif
    end
endmodule

// File: rtl/uart_hex_word_parser.sv
// uart_hex_word_parser: turns an ASCII hex byte stream into WORD_W-bit words behind a one-entry buffer.
// Backspace editing inside a token is enabled by defining RX_HEX_BKSP_EN.
module uart_hex_word_parser
    import uart_hex_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              din_vld,
    input  logic [7:0]        din_data,
    output logic              word_vld,
    output logic [WORD_W-1:0] word_data,
    output logic              word_eol,
    input  logic              word_rdy,
    output logic              err_pulse,
    output logic [1:0]        err_code
);
    localparam int MAX_DIGITS = WORD_W / 4;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    logic [2:0]        cls;
    logic [3:0]        nibble;
    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d, word_data_q, word_data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              word_vld_q, word_vld_d, word_eol_q, word_eol_d;
    logic              err_pulse_q, err_pulse_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              term, emit, load, bad, too_long, overrun;

    hex_char_classify u_cls (.din_data(din_data), .cls(cls), .nibble(nibble));

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (din_vld) begin
            case (state_q)
                S_IDLE: if (cls == CLS_DIGIT) begin
                    state_d = S_ACC;
                    acc_d = WORD_W'(nibble);
                    cnt_d = CW'(1);
                end
                S_ACC: case (cls)
                    CLS_DIGIT: if (cnt_q == MAX_CNT) begin
                        state_d = S_DISCARD;
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        acc_d = {acc_q[WORD_W-5:0], nibble};
                        cnt_d = cnt_q + CW'(1);
                    end
                    CLS_SEP, CLS_EOL: begin
                        state_d = S_IDLE;
                        acc_d = '0;
                        cnt_d = '0;
                    end
                    CLS_BS: begin
                        // erasing the last held digit leaves an empty token
                        state_d = cnt_q == CW'(1) ? S_IDLE : S_ACC;
                        acc_d = acc_q >> 4;
                        cnt_d = cnt_q - CW'(1);
                    end
                    default: begin
                        state_d = S_DISCARD;
                        acc_d = '0;
                        cnt_d = '0;
                    end
                endcase
                default: if (cls == CLS_SEP || cls == CLS_EOL) state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        term = cls == CLS_SEP || cls == CLS_EOL;
        emit = din_vld && state_q == S_ACC && term;
        load = emit && (!word_vld_q || word_rdy);
        overrun = emit && !load;
        bad = din_vld && state_q != S_DISCARD && cls == CLS_BAD;
        too_long = din_vld && state_q == S_ACC && cls == CLS_DIGIT && cnt_q == MAX_CNT;
        word_vld_d = load || (word_vld_q && !word_rdy);
        word_data_d = load ? acc_q : word_data_q;
        word_eol_d = load ? cls == CLS_EOL : word_eol_q;
        err_pulse_d = bad || too_long || overrun;
        err_code_d = bad ? ERR_BADCHAR : too_long ? ERR_TOOLONG : overrun ? ERR_OVERRUN : err_code_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            word_vld_q  <= 1'b0;
            word_data_q <= '0;
            word_eol_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            word_vld_q  <= word_vld_d;
            word_data_q <= word_data_d;
            word_eol_q  <= word_eol_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    assign word_vld  = word_vld_q;
    assign word_data = word_data_q;
    assign word_eol  = word_eol_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_uart_hex_word_parser.sv
// tb_uart_hex_word_parser: directed test-plan scenarios plus random byte streams against a token-level model.
module tb_uart_hex_word_parser;
`ifdef RX_HEX_BKSP_EN
    localparam bit BKSP = 1'b1;
`else
    localparam bit BKSP = 1'b0;
`endif

    logic        clk = 1'b0, rstn = 1'b0, din_vld = 1'b0, word_rdy = 1'b1;
    logic [7:0]  din_data = 8'h00;
    logic        word_vld, word_eol, err_pulse;
    logic [31:0] word_data;
    logic [1:0]  err_code;
    int          tests = 0, fails = 0;
    logic [32:0] got_w[$], exp_w[$];
    logic [1:0]  got_e[$], exp_e[$];

    always #5 clk = ~clk;

    uart_hex_word_parser dut (
        .clk(clk), .rstn(rstn), .din_vld(din_vld), .din_data(din_data),
        .word_vld(word_vld), .word_data(word_data), .word_eol(word_eol), .word_rdy(word_rdy),
        .err_pulse(err_pulse), .err_code(err_code)
    );

    // Observed transfers and error strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (rstn) begin
            if (word_vld && word_rdy) got_w.push_back({word_eol, word_data});
            if (err_pulse) got_e.push_back(err_code);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        din_vld = 1'b1;
        din_data = b;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        din_data = 8'($urandom);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic clear_obs();
        got_w.delete();
        got_e.delete();
    endtask

    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c >= "a") return 4'(c - 8'h61 + 8'd10);
        if (c >= "A") return 4'(c - 8'h41 + 8'd10);
        return 4'(c - 8'h30);
    endfunction

    // Token-level reference: digits collect in a list; a terminator emits the list as a number
    function automatic void model(input logic [7:0] s[$]);
        logic [3:0]  dg[$];
        bit          disc, dig, term, bs;
        logic [31:0] v;
        logic [7:0]  c;
        disc = 1'b0;
        exp_w.delete();
        exp_e.delete();
        foreach (s[i]) begin
            c = s[i];
            dig = (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
            term = c == 8'h20 || c == 8'h2C || c == 8'h0D || c == 8'h0A;
            bs = BKSP && (c == 8'h08 || c == 8'h7F);
            if (term) begin
                if (!disc && dg.size() > 0) begin
                    v = 0;
                    foreach (dg[k]) v = (v << 4) | 32'(dg[k]);
                    exp_w.push_back({c == 8'h0D || c == 8'h0A, v});
                end
                dg.delete();
                disc = 1'b0;
            end else if (!disc) begin
                if (dig) begin
                    if (dg.size() == 8) begin
                        exp_e.push_back(2'd2);
                        disc = 1'b1;
                        dg.delete();
                    end else dg.push_back(hexval(c));
                end else if (bs) begin
                    if (dg.size() > 0) void'(dg.pop_back());
                end else begin
                    exp_e.push_back(2'd1);
                    if (dg.size() > 0) begin
                        disc = 1'b1;
                        dg.delete();
                    end
                end
            end
        end
    endfunction

    function automatic logic [7:0] rnd_byte();
        logic [7:0] bads[6] = '{8'h47, 8'h7A, 8'h21, 8'h00, 8'hFF, 8'h3A};
        int r = $urandom_range(0, 99);
        int v = $urandom_range(0, 15);
        if (r < 72) return v < 10 ? 8'(8'h30 + v) : 8'(($urandom_range(0, 1) ? 8'h61 : 8'h41) + v - 10);
        if (r < 80) return $urandom_range(0, 1) ? 8'h20 : 8'h2C;
        if (r < 86) return $urandom_range(0, 1) ? 8'h0D : 8'h0A;
        if (r < 94) return bads[$urandom_range(0, 5)];
        return $urandom_range(0, 1) ? 8'h08 : 8'h7F;
    endfunction

    task automatic test_reset();
        tick(2);
        tests++;
        if (word_vld !== 1'b0 || word_data !== 32'h0 || word_eol !== 1'b0) begin
            fails++;
            $display("FAIL reset_word vld=%b data=%h eol=%b, want 0 0 0", word_vld, word_data, word_eol);
        end
        tests++;
        if (err_pulse !== 1'b0 || err_code !== 2'd0) begin
            fails++;
            $display("FAIL reset_err pulse=%b code=%0d, want 0 0", err_pulse, err_code);
        end
        rstn = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        clear_obs();
        send_str("1A2b");
        tests++;
        if (word_vld !== 1'b0) begin
            fails++;
            $display("FAIL basic_early vld=%b, want 0", word_vld);
        end
        send_str("\r");
        tests++;
        if (word_vld !== 1'b1 || word_data !== 32'h1A2B || word_eol !== 1'b1) begin
            fails++;
            $display("FAIL basic_latency vld=%b data=%h eol=%b, want 1 00001a2b 1", word_vld, word_data, word_eol);
        end
        tick(3);
        tests++;
        if (got_w.size() != 1 || got_e.size() != 0 || word_vld !== 1'b0) begin
            fails++;
            $display("FAIL basic_count words=%0d errs=%0d vld=%b, want 1 0 0", got_w.size(), got_e.size(), word_vld);
        end
    endtask

    task automatic test_two_words();
        clear_obs();
        send_str("DEADBEEF,12 ");
        tick(3);
        tests++;
        if (got_w.size() != 2 || got_w[0] !== {1'b0, 32'hDEADBEEF} || got_w[1] !== {1'b0, 32'h12} || got_e.size() != 0) begin
            fails++;
            $display("FAIL two_words got %p errs %p, want {0deadbeef,000000012} no errs", got_w, got_e);
        end
    endtask

    task automatic test_toolong();
        clear_obs();
        send_str("123456789 5\n");
        tick(3);
        tests++;
        if (got_w.size() != 1 || got_w[0] !== {1'b1, 32'h5}) begin
            fails++;
            $display("FAIL toolong_words got %p, want {100000005}", got_w);
        end
        tests++;
        if (got_e.size() != 1 || got_e[0] !== 2'd2) begin
            fails++;
            $display("FAIL toolong_errs got %p, want {2}", got_e);
        end
    endtask

    task automatic test_badchar();
        clear_obs();
        send_str("4G7 8\r");
        tick(3);
        tests++;
        if (got_w.size() != 1 || got_w[0] !== {1'b1, 32'h8}) begin
            fails++;
            $display("FAIL badchar_words got %p, want {100000008}", got_w);
        end
        tests++;
        if (got_e.size() != 1 || got_e[0] !== 2'd1) begin
            fails++;
            $display("FAIL badchar_errs got %p, want {1}", got_e);
        end
    endtask

    task automatic test_overrun();
        clear_obs();
        word_rdy = 1'b0;
        send_str("1 ");
        tests++;
        if (word_vld !== 1'b1 || word_data !== 32'h1) begin
            fails++;
            $display("FAIL overrun_first vld=%b data=%h, want 1 00000001", word_vld, word_data);
        end
        send_str("2 ");
        tests++;
        if (err_pulse !== 1'b1 || err_code !== 2'd3 || word_data !== 32'h1 || word_eol !== 1'b0) begin
            fails++;
            $display("FAIL overrun_err pulse=%b code=%0d data=%h eol=%b, want 1 3 00000001 0", err_pulse, err_code, word_data, word_eol);
        end
        tick(2);
        tests++;
        if (err_pulse !== 1'b0 || err_code !== 2'd3 || word_vld !== 1'b1 || word_data !== 32'h1) begin
            fails++;
            $display("FAIL overrun_hold pulse=%b code=%0d vld=%b data=%h, want 0 3 1 00000001", err_pulse, err_code, word_vld, word_data);
        end
        word_rdy = 1'b1;
        tick(1);
        tests++;
        if (word_vld !== 1'b0 || got_w.size() != 1 || got_w[0] !== {1'b0, 32'h1} || got_e.size() != 1) begin
            fails++;
            $display("FAIL overrun_drain vld=%b words %p errs %p, want 0 {000000001} {3}", word_vld, got_w, got_e);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        word_rdy = 1'b0;
        send_str("5 G");
        send_str("AB");
        tests++;
        if (word_vld !== 1'b1 || err_code !== 2'd1) begin
            fails++;
            $display("FAIL rstmid_pre vld=%b code=%0d, want 1 1", word_vld, err_code);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests++;
        if (word_vld !== 1'b0 || word_data !== 32'h0 || err_code !== 2'd0) begin
            fails++;
            $display("FAIL rstmid_async vld=%b data=%h code=%0d, want 0 0 0", word_vld, word_data, err_code);
        end
        tick(3);
        rstn = 1'b1;
        clear_obs();
        word_rdy = 1'b1;
        send_str("C\r");
        tick(3);
        tests++;
        if (got_w.size() != 1 || got_w[0] !== {1'b1, 32'hC} || got_e.size() != 0) begin
            fails++;
            $display("FAIL rstmid_words got %p errs %p, want {10000000c} no errs", got_w, got_e);
        end
    endtask

    task automatic test_bksp();
        logic [7:0] q[$];
        q = '{8'h31, 8'h32, 8'h08, 8'h33, 8'h0D, 8'h35, 8'h7F, 8'h7F, 8'h37, 8'h20};
        model(q);
        clear_obs();
        foreach (q[i]) send(q[i]);
        tick(3);
        tests++;
        if (got_w.size() == 0 || got_w[0] !== {1'b1, 32'h13}) begin
            if (BKSP) begin
                fails++;
                $display("FAIL bksp_first got %p, want first 100000013", got_w);
            end
        end
        tests++;
        if (got_w != exp_w || got_e != exp_e) begin
            fails++;
            $display("FAIL bksp_stream words %p errs %p, want %p %p", got_w, got_e, exp_w, exp_e);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        for (int r = 0; r < 10; r++) begin
            q.delete();
            repeat (60) q.push_back(rnd_byte());
            q.push_back(8'h20);
            model(q);
            clear_obs();
            foreach (q[i]) begin
                send(q[i]);
                tick($urandom_range(0, 2));
            end
            tick(3);
            tests++;
            if (got_w.size() != exp_w.size()) begin
                fails++;
                $display("FAIL rand_nwords round %0d got %0d want %0d", r, got_w.size(), exp_w.size());
            end else foreach (exp_w[i]) begin
                tests++;
                if (got_w[i] !== exp_w[i]) begin
                    fails++;
                    $display("FAIL rand_word round %0d idx %0d got %h want %h", r, i, got_w[i], exp_w[i]);
                end
            end
            tests++;
            if (got_e != exp_e) begin
                fails++;
                $display("FAIL rand_errs round %0d got %p want %p", r, got_e, exp_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_words();
        test_toolong();
        test_badchar();
        test_overrun();
        test_reset_mid();
        test_bksp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_hex_word_parser.md
Name: uart_hex_word_parser

Overview:
- Sits directly downstream of the UART byte receiver in the PDU and consumes its one-cycle `din_vld` / `din_data` byte strobes.
- Converts an ASCII hex stream (e.g. "1A2b 3C\r") into WORD_W-bit words.
- Presents each word through a one-entry valid/ready output buffer to the PDU command logic.
- Flags bad characters, over-long tokens and output overrun.

Parameters:
- WORD_W, 32, output word width; must be a multiple of 4.
- MAX_DIGITS (localparam), WORD_W/4, maximum hex digits per token.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- din_vld  in  1  byte valid; single-cycle pulse from the UART receiver.
- din_data  in  8  received ASCII byte; sampled only when din_vld=1.
- word_vld  out  1  output buffer holds a word.
- word_data  out  WORD_W  parsed word, zero-extended on the left.
- word_eol  out  1  word was terminated by CR/LF (1) or by separator (0).
- word_rdy  in  1  consumer accepts; transfer when word_vld & word_rdy.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  1=BADCHAR, 2=TOOLONG, 3=OVERRUN; holds last error until the next error.

Behaviour:
- Reset (rstn=0, async): state=S_IDLE, acc=0, cnt=0, word_vld=0, word_data=0, word_eol=0, err_pulse=0, err_code=0.
- Character classes:
  - DIGIT: '0'-'9', 'a'-'f', 'A'-'F'; nibble value 0-15.
  - SEP: 0x20, 0x2C.
  - EOL: 0x0D, 0x0A.
  - everything else: BAD.
- All state updates occur only on cycles with din_vld=1; otherwise state, acc and cnt hold.
- S_IDLE (no digits held):
  - DIGIT -> acc=nibble, cnt=1, go S_ACC.
  - SEP/EOL -> ignored, so empty tokens and "\r\n" pairs produce nothing.
  - BAD -> err BADCHAR, stay in S_IDLE.
- S_ACC:
  - DIGIT with cnt<MAX_DIGITS -> acc={acc[WORD_W-5:0],nibble}, cnt+1.
  - DIGIT with cnt==MAX_DIGITS -> err TOOLONG, acc=0, go S_DISCARD.
  - SEP -> emit(acc, eol=0), go S_IDLE.
  - EOL -> emit(acc, eol=1), go S_IDLE.
  - BAD -> err BADCHAR, acc=0, go S_DISCARD.
- S_DISCARD:
  - SEP/EOL -> go S_IDLE, no emit.
  - all other bytes ignored; no further errors.
- Emit:
  - word_vld/word_data/word_eol update on the clock edge after the terminator's din_vld; latency 1 cycle.
  - Buffer free (word_vld=0), or being drained the same cycle (word_vld & word_rdy) -> load new word, word_vld=1.
  - Buffer full and not drained -> new word dropped, old word unchanged, err OVERRUN.
- Output buffer: word_vld clears the cycle after a transfer unless a new emit loads it in that same cycle. word_data and word_eol are stable while word_vld=1 and word_rdy=0.
- err_pulse is high for exactly one cycle per error. At most one error per byte, so no priority conflict.
- acc/cnt are cleared on every return to S_IDLE.

Optional Feature:
- RX_HEX_BKSP_EN defined:
  - bytes 0x08 and 0x7F in S_ACC perform acc=acc>>4, cnt-1; if cnt reaches 0, go S_IDLE.
  - in S_IDLE and S_DISCARD these bytes are ignored; no error.
- RX_HEX_BKSP_EN undefined: 0x08/0x7F are class BAD.

Decomposition:
- Package uart_hex_pkg holds:
  - ASCII constants: CH_SP, CH_COMMA, CH_CR, CH_LF, CH_BS, CH_DEL.
  - err codes: ERR_NONE, ERR_BADCHAR, ERR_TOOLONG, ERR_OVERRUN.
  - state encoding: S_IDLE, S_ACC, S_DISCARD.
  - char class encoding: CLS_DIGIT, CLS_SEP, CLS_EOL, CLS_BS, CLS_BAD.
- Sub-module hex_char_classify: purely combinational; din_data -> class[2:0], nibble[3:0]. BS is reported only under RX_HEX_BKSP_EN.

Test Plan:
- "1A2b\r" with word_rdy=1 -> one word 0x00001A2B, eol=1, word_vld high 1 cycle after the CR strobe; no err_pulse.
- "DEADBEEF,12 " with word_rdy=1 -> 0xDEADBEEF eol=0, then 0x00000012 eol=0; no err_pulse.
- "123456789 5\n" -> TOOLONG on the 9th digit; no word for the long token; then 0x00000005 eol=1.
- "4G7 8\r" -> BADCHAR at 'G'; "7" discarded; then 0x00000008 eol=1.
- word_rdy=0, "1 2 " -> word 0x1 held; OVERRUN on the second emit; raising word_rdy transfers 0x1 and word_vld then drops.
- Reset mid-token: "AB", then rstn low 3 cycles, then "C\r" -> only 0x0000000C.
- Under RX_HEX_BKSP_EN: "12\x083\r" -> 0x00000013.
